// File: rtl/mccpu.sv
// Multi-cycle MIPS-subset CPU: five-state Moore FSM (FETCH/DECODE/EXEC/MEM/WB)
// sharing one memory port between instruction fetch and load/store.
module mccpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DATA_W   = 32,
    parameter int          NREG     = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       PC,
    output logic              illegal,
    input  logic [4:0]        reg_sel,
    output logic [DATA_W-1:0] reg_data
);
    localparam int RIDX_W = $clog2(NREG);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("mccpu: DATA_W must be 32");
        end
        if (NREG != 16 && NREG != 32) begin : g_bad_nreg
            $error("mccpu: NREG must be 16 or 32");
        end
    endgenerate

    state_t            r_state, w_state_nx;
    logic [31:0]       r_pc, r_ir;
    logic [DATA_W-1:0] r_regs [NREG];
    logic [DATA_W-1:0] r_a, r_b, r_imm, r_alu, r_mdr;

    logic [5:0]        w_op, w_funct;
    logic [4:0]        w_rs, w_rt, w_rd, w_shamt;
    logic              w_rtype, w_is_jr, w_is_lw, w_is_sw, w_is_beq, w_is_j, w_is_jal, w_is_ori;
    logic              w_legal, w_slt;
    logic [31:0]       w_pc4, w_pc_nx;
    logic              w_pc_we;
    logic              w_rf_we;
    logic [4:0]        w_rf_waddr;
    logic [DATA_W-1:0] w_rf_wdata, w_rs_val, w_rt_val, w_alu;
    logic signed [DATA_W-1:0] w_a_s, w_b_s;

    // Register 0 and indices beyond the implemented file read as zero and ignore writes.
    function automatic logic f_reg_ok(input logic [4:0] idx);
        return (idx != 5'd0) && (int'(idx) < NREG);
    endfunction

    assign w_op     = r_ir[31:26];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_shamt  = r_ir[10:6];
    assign w_funct  = r_ir[5:0];
    assign w_rtype  = (w_op == 6'h00);
    assign w_is_jr  = w_rtype && (w_funct == 6'h08);
    assign w_is_lw  = (w_op == 6'h23);
    assign w_is_sw  = (w_op == 6'h2B);
    assign w_is_beq = (w_op == 6'h04);
    assign w_is_j   = (w_op == 6'h02);
    assign w_is_jal = (w_op == 6'h03);
    assign w_is_ori = (w_op == 6'h0D);
    assign w_pc4    = r_pc + 32'd4;
    assign PC       = r_pc;
    assign w_a_s    = r_a;
    assign w_b_s    = r_b;
    assign w_slt    = (w_a_s < w_b_s);

    assign w_rs_val  = f_reg_ok(w_rs)    ? r_regs[w_rs[RIDX_W-1:0]]    : '0;
    assign w_rt_val  = f_reg_ok(w_rt)    ? r_regs[w_rt[RIDX_W-1:0]]    : '0;
    assign reg_data  = f_reg_ok(reg_sel) ? r_regs[reg_sel[RIDX_W-1:0]] : '0;
    assign mem_wdata = r_b;

    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            6'h00: begin
                case (w_funct)
                    6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h08: w_legal = 1'b1;
                    default: w_legal = 1'b0;
                endcase
            end
            6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_alu = r_a + r_imm;
        if (w_rtype) begin
            case (w_funct)
                6'h21:   w_alu = r_a + r_b;
                6'h23:   w_alu = r_a - r_b;
                6'h24:   w_alu = r_a & r_b;
                6'h25:   w_alu = r_a | r_b;
                6'h2A:   w_alu = {{(DATA_W-1){1'b0}}, w_slt};
                6'h00:   w_alu = r_b << w_shamt;
                default: w_alu = r_a + r_b;
            endcase
        end else if (w_is_ori) begin
            w_alu = r_a | r_imm;
        end
    end

    // Next state and Moore outputs; the memory strobes are gated while rst is high.
    always_comb begin
        w_state_nx = r_state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = r_pc;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) w_state_nx = S_DECODE;
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_state_nx = S_EXEC;
                end else begin
                    illegal    = 1'b1;
                    w_state_nx = S_FETCH;
                end
            end
            S_EXEC: begin
                if (w_is_lw || w_is_sw)                          w_state_nx = S_MEM;
                else if (w_is_beq || w_is_j || w_is_jal || w_is_jr) w_state_nx = S_FETCH;
                else                                             w_state_nx = S_WB;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = w_is_sw;
                mem_addr = {r_alu[31:2], 2'b00};
                if (mem_ready) w_state_nx = w_is_sw ? S_FETCH : S_WB;
            end
            S_WB:    w_state_nx = S_FETCH;
            default: w_state_nx = S_FETCH;
        endcase
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

    always_comb begin
        w_pc_we    = 1'b0;
        w_pc_nx    = w_pc4;
        w_rf_we    = 1'b0;
        w_rf_waddr = w_rd;
        w_rf_wdata = r_alu;
        case (r_state)
            S_DECODE: w_pc_we = !w_legal;
            S_EXEC: begin
                if (w_is_beq) begin
                    w_pc_we = 1'b1;
                    if (r_a == r_b) w_pc_nx = w_pc4 + {r_imm[DATA_W-3:0], 2'b00};
                end else if (w_is_j || w_is_jal) begin
                    w_pc_we = 1'b1;
                    w_pc_nx = {w_pc4[31:28], r_ir[25:0], 2'b00};
                end else if (w_is_jr) begin
                    w_pc_we = 1'b1;
                    w_pc_nx = r_a;
                end
                if (w_is_jal) begin
                    w_rf_we    = 1'b1;
                    w_rf_waddr = 5'd31;
                    w_rf_wdata = w_pc4;
                end
            end
            S_MEM: w_pc_we = w_is_sw && mem_ready;
            S_WB: begin
                w_pc_we    = 1'b1;
                w_rf_we    = 1'b1;
                w_rf_waddr = w_rtype ? w_rd : w_rt;
                w_rf_wdata = w_is_lw ? r_mdr : r_alu;
            end
            default: w_pc_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == S_FETCH && mem_ready) r_ir <= mem_rdata;
            if (w_pc_we) r_pc <= w_pc_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (w_rf_we && f_reg_ok(w_rf_waddr)) begin
            r_regs[w_rf_waddr[RIDX_W-1:0]] <= w_rf_wdata;
        end
    end

    // Operand/result latches are never observed before being written by their own state.
    always_ff @(posedge clk) begin
        if (r_state == S_DECODE) begin
            r_a   <= w_rs_val;
            r_b   <= w_rt_val;
            r_imm <= w_is_ori ? {{(DATA_W-16){1'b0}}, r_ir[15:0]}
                              : {{(DATA_W-16){r_ir[15]}}, r_ir[15:0]};
        end
        if (r_state == S_EXEC) r_alu <= w_alu;
        if (r_state == S_MEM && mem_ready && w_is_lw) r_mdr <= mem_rdata;
    end
endmodule

// File: doc/mccpu.md
MCCPU -- requirements
Module: mccpu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter DATA_W, default 32, datapath, register and memory word width (legal: 32 only in this revision; other values SHALL fail elaboration).
REQ-003 Parameter NREG, default 32, number of general registers (legal 16 or 32); register index above NREG-1 reads 0 and writes are discarded.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 mem_req  out  1  memory access request (single shared instruction/data port).
REQ-007 mem_we  out  1  request is a write (valid only with mem_req).
REQ-008 mem_addr  out  32  byte address, word aligned.
REQ-009 mem_wdata  out  DATA_W  store data.
REQ-010 mem_rdata  in  DATA_W  load/fetch data, valid when mem_ready=1.
REQ-011 mem_ready  in  1  access completes in the cycle mem_req=1 and mem_ready=1.
REQ-012 PC  out  32  current instruction address.
REQ-013 illegal  out  1  one-cycle pulse in DECODE on unsupported encoding.
REQ-014 reg_sel  in  5  debug register select; reg_data  out  DATA_W  combinational read of that register.

Function
REQ-015 Moore FSM states FETCH, DECODE, EXEC, MEM, WB; mem_req=1 only in FETCH and MEM.
REQ-016 FETCH: mem_addr=PC, mem_we=0; hold state, mem_addr and mem_req until mem_ready; on ready latch IR and go DECODE.
REQ-017 DECODE: read rs/rt into A/B latches, sign- or zero-extend imm16; go EXEC, or FETCH with PC+4 and illegal=1 if unsupported.
REQ-018 Supported: R-type addu(21h) subu(23h) and(24h) or(25h) slt(2Ah, signed) sll(00h, shamt) jr(08h); addi(08h) ori(0Dh, zero-ext) lw(23h) sw(2Bh) beq(04h) j(02h) jal(03h).
REQ-019 EXEC: ALU op; beq -> PC = taken ? PC+4+(sext(imm)<<2) : PC+4, go FETCH; j -> PC={PC+4[31:28],imm26,2'b00}; jal same plus r31<=PC+4; jr -> PC=rs; all jumps go FETCH.
REQ-020 EXEC for lw/sw computes rs+sext(imm), go MEM; ALU/immediate ops go WB.
REQ-021 MEM: mem_addr=EA, mem_we=1 for sw with mem_wdata=rt; hold until mem_ready; sw -> PC+4, FETCH; lw latches mem_rdata, go WB.
REQ-022 WB: write rd (R-type) or rt (I-type, lw), PC<=PC+4, go FETCH.
REQ-023 Register 0 reads 0 always; writes to it discarded.
REQ-024 Arithmetic wraps modulo 2^32; no overflow trap for addi/addu.
REQ-025 Zero-wait latency: R/imm 4 cycles, lw 5, sw 4, beq/j/jal/jr 3; each wait cycle of mem_ready adds one.
REQ-026 mem_addr[1:0] SHALL be 00; unaligned EA bits [1:0] forced to 0.
REQ-027 Writeback and PC update in same edge; register read in DECODE sees writes of all prior instructions.

Reset
REQ-028 rst=1 asynchronously: state FETCH, PC=RESET_PC, all registers 0, IR 0, illegal 0.
REQ-029 While rst=1, mem_req=0 and mem_we=0 (gated); first fetch request in the first cycle after rst deasserts.
REQ-030 rst mid-access (mem_req=1, mem_ready=0) abandons the access; no register or PC side-effect survives.

Verification
REQ-031 Zero-wait: ori r1,r0,5; addu r2,r1,r1 -> r2=10 after 8 cycles from first fetch; PC=8.
REQ-032 sw r2,4(r0) then lw r3,4(r0) with mem_ready held low 3 cycles each access -> mem_we=1 at addr 4 data 10; r3=10; mem_req stable during waits.
REQ-033 beq r1,r1,-1 at PC=0x10 -> PC=0x10 repeatedly, 3 cycles per loop; beq r1,r0 not taken -> PC=0x14.
REQ-034 jal 0x40 at PC=0x8 -> r31=0xC, PC=0x100; jr r31 -> PC=0xC.
REQ-035 Opcode 3Fh -> illegal pulse one cycle, no register write, PC+=4; addi r0,r0,1 -> r0 stays 0.
REQ-036 rst asserted in MEM of sw -> mem_req drops immediately, PC=RESET_PC, registers 0, no completed write.
